// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative shift-add
// multiplier and the EX/MEM pipeline register.
module ex_stage #(
   parameter int unsigned MUL_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic [1:0]  control_WB_s3,
   input  logic [1:0]  control_MEM_s3,
   input  logic [3:0]  control_EX_s3,
   input  logic [31:0] rs_data_s3,
   input  logic [31:0] rt_data_s3,
   input  logic [31:0] seimm_s3,
   input  logic [4:0]  rs_addr_s3,
   input  logic [4:0]  rt_addr_s3,
   input  logic [4:0]  rd_addr_s3,
   input  logic        exmem_regwrite_i,
   input  logic [4:0]  exmem_rd_i,
   input  logic [31:0] exmem_data_i,
   input  logic        memwb_regwrite_i,
   input  logic [4:0]  memwb_rd_i,
   input  logic [31:0] memwb_data_i,
   input  logic        mem_stall_i,
   output logic        ex_stall_o,
   output logic [1:0]  control_WB_s4,
   output logic [1:0]  control_MEM_s4,
   output logic [31:0] alu_result_s4,
   output logic [31:0] rt_data_s4,
   output logic [4:0]  wr_addr_s4
);

   localparam int unsigned CntW = $clog2(MUL_CYCLES) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(MUL_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;
   typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluMul} alu_op_e;

   logic [31:0] fwd_a, fwd_b, alu_b, alu_result, ex_result;
   logic [4:0]  wr_addr;
   logic [5:0]  funct;
   logic        is_mul;
   alu_op_e     alu_op;

   mul_state_e    state_q, state_d;
   logic [31:0]   mul_a_q, mul_a_d;
   logic [31:0]   mul_b_q, mul_b_d;
   logic [31:0]   prod_q, prod_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [1:0]  wb_q, mem_q;
   logic [31:0] alu_q, rt_q;
   logic [4:0]  wr_q;

   assign funct   = seimm_s3[5:0];
   assign alu_b   = control_EX_s3[3] ? seimm_s3 : fwd_b;
   assign wr_addr = control_EX_s3[2] ? rd_addr_s3 : rt_addr_s3;

   // Operand forwarding; EX/MEM wins over MEM/WB, r0 never forwards.
   always_comb begin
      fwd_a = rs_data_s3;
      fwd_b = rt_data_s3;
      if (exmem_regwrite_i && exmem_rd_i != 5'd0 && exmem_rd_i == rs_addr_s3) begin
         fwd_a = exmem_data_i;
      end else if (memwb_regwrite_i && memwb_rd_i != 5'd0 && memwb_rd_i == rs_addr_s3) begin
         fwd_a = memwb_data_i;
      end
      if (exmem_regwrite_i && exmem_rd_i != 5'd0 && exmem_rd_i == rt_addr_s3) begin
         fwd_b = exmem_data_i;
      end else if (memwb_regwrite_i && memwb_rd_i != 5'd0 && memwb_rd_i == rt_addr_s3) begin
         fwd_b = memwb_data_i;
      end
   end

   // ALUOp / funct decode; anything unrecognised falls back to add.
   always_comb begin
      alu_op = AluAdd;
      unique case (control_EX_s3[1:0])
         2'b01: alu_op = AluSub;
         2'b10: begin
            unique case (funct)
               6'h22:   alu_op = AluSub;
               6'h24:   alu_op = AluAnd;
               6'h25:   alu_op = AluOr;
               6'h2A:   alu_op = AluSlt;
               6'h18:   alu_op = AluMul;
               default: alu_op = AluAdd;
            endcase
         end
         default: alu_op = AluAdd;
      endcase
   end

   assign is_mul = (alu_op == AluMul);

   // Single-cycle ALU; mul results come from the multiplier instead.
   always_comb begin
      alu_result = fwd_a + alu_b;
      unique case (alu_op)
         AluSub:  alu_result = fwd_a - alu_b;
         AluAnd:  alu_result = fwd_a & alu_b;
         AluOr:   alu_result = fwd_a | alu_b;
         AluSlt:  alu_result = {31'd0, $signed(fwd_a) < $signed(alu_b)};
         default: alu_result = fwd_a + alu_b;
      endcase
   end

   assign ex_result  = (state_q == StDone) ? prod_q : alu_result;
   assign ex_stall_o = ((state_q == StIdle) && is_mul && !mem_stall_i) || (state_q == StBusy);

   // Multiplier next state: latch operands, then one shift-add step per cycle.
   always_comb begin
      state_d = state_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (is_mul && !mem_stall_i) begin
               mul_a_d = fwd_a;
               mul_b_d = fwd_b;
               prod_d  = '0;
               cnt_d   = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (mul_b_q[0]) begin
               prod_d = prod_q + mul_a_q;
            end
            mul_a_d = mul_a_q << 1;
            mul_b_d = mul_b_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               state_d = StDone;
            end
         end
         StDone: begin
            // Product is held here until EX/MEM is free to take it.
            if (!mem_stall_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Multiplier state register.
   always_ff @(posedge clk) begin
      if (!rst_i) begin
         state_q <= StIdle;
         mul_a_q <= '0;
         mul_b_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
      end
   end

   // EX/MEM register: hold on memory stall, bubble while the multiplier is busy.
   always_ff @(posedge clk) begin
      if (!rst_i) begin
         wb_q  <= '0;
         mem_q <= '0;
         alu_q <= '0;
         rt_q  <= '0;
         wr_q  <= '0;
      end else if (mem_stall_i) begin
         wb_q  <= wb_q;
         mem_q <= mem_q;
         alu_q <= alu_q;
         rt_q  <= rt_q;
         wr_q  <= wr_q;
      end else if (ex_stall_o) begin
         wb_q  <= '0;
         mem_q <= '0;
         alu_q <= '0;
         rt_q  <= '0;
         wr_q  <= '0;
      end else begin
         wb_q  <= control_WB_s3;
         mem_q <= control_MEM_s3;
         alu_q <= ex_result;
         rt_q  <= fwd_b;
         wr_q  <= wr_addr;
      end
   end

   assign control_WB_s4  = wb_q;
   assign control_MEM_s4 = mem_q;
   assign alu_result_s4  = alu_q;
   assign rt_data_s4     = rt_q;
   assign wr_addr_s4     = wr_q;

endmodule
